fwd_hazard_unit: RTL

- Parametrised forwarding and load-use hazard unit for the pipelined core.
- Evaluates the ID-stage instruction's source registers against the destinations of the EX through WB pipeline stages.
- Registers the forward selects so they are valid when that instruction reaches EX.
- Generates multi-cycle load-use stalls and bubbles, and keeps a saturating stall-cycle counter.

---
 rtl/fwd_hazard_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit. It compares the ID-stage sources
// against the destinations in EX..WB and emits stall/bubble plus registered selects.
module fwd_hazard_unit #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1),
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            rs_addr_id,
  input  logic [ADDR_W-1:0]            rt_addr_id,
  input  logic                         rs_used_id,
  input  logic                         rt_used_id,
  input  logic [FWD_STAGES*ADDR_W-1:0] dst_addr,
  input  logic [FWD_STAGES-1:0]        dst_we,
  input  logic                         load_ex,
  input  logic                         hold_i,
  input  logic                         flush_i,
  output logic [SEL_W-1:0]             fwd_a_sel,
  output logic [SEL_W-1:0]             fwd_b_sel,
  output logic                         stall,
  output logic                         bubble,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam int unsigned LAT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic [0:0] {IDLE, STALL} state_t;

  state_t             state;
  logic [LAT_W-1:0]   cnt;
  logic [SEL_W-1:0]   sel_a;
  logic [SEL_W-1:0]   sel_b;
  logic               found_a;
  logic               found_b;
  logic               match0_a;
  logic               match0_b;
  logic               hazard;
  logic [ADDR_W-1:0]  dst_k;

  // Scanning upward and latching the first hit makes the youngest producer win.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    dst_k   = '0;
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      dst_k = dst_addr[k*ADDR_W +: ADDR_W];
      if (!found_a && dst_we[k] && (dst_k != '0) && (dst_k == rs_addr_id) && rs_used_id) begin
        sel_a   = SEL_W'(k + 1);
        found_a = 1'b1;
      end
      if (!found_b && dst_we[k] && (dst_k != '0) && (dst_k == rt_addr_id) && rt_used_id) begin
        sel_b   = SEL_W'(k + 1);
        found_b = 1'b1;
      end
    end
  end

  always_comb begin
    match0_a = dst_we[0] && (dst_addr[0 +: ADDR_W] != '0) &&
               (dst_addr[0 +: ADDR_W] == rs_addr_id) && rs_used_id;
    match0_b = dst_we[0] && (dst_addr[0 +: ADDR_W] != '0) &&
               (dst_addr[0 +: ADDR_W] == rt_addr_id) && rt_used_id;
    hazard   = (state == IDLE) && !hold_i && !flush_i && load_ex && (match0_a || match0_b);
  end

  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    if (!rst) begin
      if (state == STALL) begin
        stall  = 1'b1;
        bubble = !hold_i;
      end else if (hazard) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  // The first stall cycle is spent in IDLE, so STALL only covers the remaining LOAD_LAT-1.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state <= STALL;
            cnt   <= LAT_W'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          if (!hold_i) begin
            if (cnt == LAT_W'(1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - LAT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      fwd_a_sel <= '0;
      fwd_b_sel <= '0;
    end else if (hold_i) begin
      fwd_a_sel <= fwd_a_sel;
      fwd_b_sel <= fwd_b_sel;
    end else if (bubble) begin
      fwd_a_sel <= '0;
      fwd_b_sel <= '0;
    end else begin
      fwd_a_sel <= sel_a;
      fwd_b_sel <= sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
